// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_add_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  localparam int SA_MAX_WIDTH = 32;
endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder cell, sequenced by serial_adder_ctrl.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement A-B.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             fa_s, fa_c, sub_i;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  serial_fa_cell u_fa (
    .a (a_q[0]),
    .b (b_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtract as A + ~B + 1; cin is ignored in that mode.
          state_d = S_RUN;
          a_d     = op_a;
          b_d     = sub_i ? ~op_b : op_b;
          carry_d = sub_i ? 1'b1 : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          sum_d   = '0;
        end
      end
      S_RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (idx_q == LAST) begin
          cout_d  = fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
